// File: rtl/lcd_bus_ctrl.sv
// rtl/lcd_bus_ctrl.sv - 8080-style write-only LCD bus controller with init ROM and command FIFO
//
// Performs the panel hard reset, streams the init ROM, issues DISP_ON,
// then drains the command FIFO through a WR_LOW/WR_HIGH write engine.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command push handshake, payload cmd_rs/cmd_data
//   fifo_count             occupied FIFO entries
//   busy, init_done        status
//   init_addr/init_rdata   init ROM port, 1-cycle latency, rdata = {valid, rs, data}
//   lcd_hw_*               panel strobes, data bus and backlight enable
module lcd_bus_ctrl #(
  parameter int          DATA_W     = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter int          RST_CYCLES = 16777216,
  parameter int          INIT_AW    = 10,
  parameter int          WR_LOW     = 1,
  parameter int          WR_HIGH    = 1,
  parameter logic [15:0] DISP_ON    = 16'h2900
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rs,
  input  logic [DATA_W-1:0]             cmd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          init_done,
  output logic [INIT_AW-1:0]            init_addr,
  input  logic [DATA_W+1:0]             init_rdata,
  output logic                          lcd_hw_rst,
  output logic                          lcd_hw_cs,
  output logic                          lcd_hw_rs,
  output logic                          lcd_hw_wr,
  output logic                          lcd_hw_rd,
  output logic [DATA_W-1:0]             lcd_hw_data,
  output logic                          lcd_hw_bl_ctr
);

  localparam int FAW    = $clog2(FIFO_DEPTH);
  localparam int PERIOD = WR_LOW + WR_HIGH;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [FAW:0] FIFO_FULL = (FAW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_HOLD   = 2'd0;
  localparam logic [1:0] S_INIT   = 2'd1;
  localparam logic [1:0] S_DISPON = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     hold_cnt;
  logic              addr_stable;
  logic              init_end;

  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]    wr_ptr;
  logic [FAW-1:0]    rd_ptr;
  logic [FAW:0]      count_next;
  logic              push;
  logic              pop;

  logic              eng_busy;
  logic [PW-1:0]     ph_cnt;
  logic              eng_last;
  logic              eng_free;
  logic              start;
  logic              start_rs;
  logic [DATA_W-1:0] start_data;
  logic              rom_valid;

  assign rom_valid = init_rdata[DATA_W+1];
  assign push      = cmd_valid && cmd_ready;

  // The final phase of a write doubles as the issue slot of the next one,
  // which is what gives gap-free back-to-back words.
  assign eng_last  = eng_busy && (ph_cnt == PW'(PERIOD-1));
  assign eng_free  = !eng_busy || eng_last;

  always_comb begin
    start      = 1'b0;
    start_rs   = 1'b0;
    start_data = '0;
    pop        = 1'b0;
    case (state)
      // addr_stable marks that init_rdata belongs to the current init_addr,
      // so a word is never taken from the previous address.
      S_INIT: if (eng_free && addr_stable && !init_end && rom_valid) begin
        start      = 1'b1;
        start_rs   = init_rdata[DATA_W];
        start_data = init_rdata[DATA_W-1:0];
      end
      S_DISPON: if (!eng_busy) begin
        start      = 1'b1;
        start_data = DISP_ON[DATA_W-1:0];
      end
      S_RUN: if (eng_free && fifo_count != '0) begin
        start                  = 1'b1;
        pop                    = 1'b1;
        {start_rs, start_data} = fifo_mem[rd_ptr];
      end
      default: ;
    endcase
  end

  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_rs, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      init_addr   <= '0;
      addr_stable <= 1'b0;
      init_end    <= 1'b0;
      init_done   <= 1'b0;
      eng_busy    <= 1'b0;
      ph_cnt      <= '0;
      lcd_hw_wr   <= 1'b1;
      lcd_hw_rs   <= 1'b0;
      lcd_hw_data <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      cmd_ready   <= 1'b0;
    end else begin
      if (start) begin
        eng_busy    <= 1'b1;
        ph_cnt      <= '0;
        lcd_hw_wr   <= 1'b0;
        lcd_hw_rs   <= start_rs;
        lcd_hw_data <= start_data;
      end else if (eng_busy) begin
        if (eng_last) begin
          eng_busy <= 1'b0;
        end else begin
          ph_cnt <= ph_cnt + 1'b1;
          if (ph_cnt == PW'(WR_LOW-1)) lcd_hw_wr <= 1'b1;
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      cmd_ready  <= (count_next != FIFO_FULL);

      case (state)
        S_HOLD: begin
          if (hold_cnt == CW'(RST_CYCLES-1)) begin
            state       <= S_INIT;
            init_addr   <= '0;
            addr_stable <= 1'b0;
            init_end    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_INIT: begin
          addr_stable <= 1'b1;
          if (start) begin
            // The last ROM address ends the sequence instead of wrapping.
            if (init_addr == '1) begin
              init_end <= 1'b1;
            end else begin
              init_addr   <= init_addr + 1'b1;
              addr_stable <= 1'b0;
            end
          end else if (addr_stable && !init_end && !rom_valid) begin
            init_end <= 1'b1;
          end
          if (init_end && !eng_busy) state <= S_DISPON;
        end
        S_DISPON: begin
          if (eng_last) begin
            init_done <= 1'b1;
            state     <= S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = !(state == S_RUN && fifo_count == '0 && !eng_busy);
  assign lcd_hw_rst    = (state != S_HOLD);
  assign lcd_hw_cs     = 1'b0;
  assign lcd_hw_rd     = 1'b1;
  assign lcd_hw_bl_ctr = 1'b1;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb/tb_lcd_bus_ctrl.sv - self-checking bench for lcd_bus_ctrl
module tb_lcd_bus_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int RSTC  = 8;
  localparam int AW    = 10;
  localparam int WL    = 2;
  localparam int WH    = 3;
  localparam int P     = WL + WH;
  localparam int ROM_N = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_rs = 1'b0;
  logic [DW-1:0]   cmd_data = '0;
  logic            cmd_ready;
  logic [2:0]      fifo_count;
  logic            busy;
  logic            init_done;
  logic [AW-1:0]   init_addr;
  logic [DW+1:0]   init_rdata;
  logic            lcd_hw_rst, lcd_hw_cs, lcd_hw_rs, lcd_hw_wr, lcd_hw_rd, lcd_hw_bl_ctr;
  logic [DW-1:0]   lcd_hw_data;

  lcd_bus_ctrl #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RST_CYCLES(RSTC), .INIT_AW(AW),
    .WR_LOW(WL), .WR_HIGH(WH), .DISP_ON(16'h2900)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
    .fifo_count(fifo_count), .busy(busy), .init_done(init_done),
    .init_addr(init_addr), .init_rdata(init_rdata),
    .lcd_hw_rst(lcd_hw_rst), .lcd_hw_cs(lcd_hw_cs), .lcd_hw_rs(lcd_hw_rs),
    .lcd_hw_wr(lcd_hw_wr), .lcd_hw_rd(lcd_hw_rd), .lcd_hw_data(lcd_hw_data),
    .lcd_hw_bl_ctr(lcd_hw_bl_ctr)
  );

  logic [DW+1:0] rom [ROM_N];
  always @(posedge clk) init_rdata <= rom[init_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Inputs as seen by the DUT at each active edge.
  logic          s_resetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_rs = 1'b0;
  logic [DW-1:0] s_data = '0;
  always @(posedge clk) begin
    s_resetn <= resetn;
    s_valid  <= cmd_valid;
    s_rs     <= cmd_rs;
    s_data   <= cmd_data;
  end

  // Behavioural model: expected write stream and FIFO occupancy.
  logic [DW:0] exp_init[$];
  logic [DW:0] m_fifo[$];
  logic [DW:0] bus_log[$];
  int          fall_t[$];
  int          m_count = 0;
  logic        m_ready = 1'b0;
  logic        m_done = 1'b0;
  int          hold_edges = 0;
  int          since = P;
  int          writes = 0;
  int          low_run = 0;
  int          sample_no = 0;
  logic        had_write = 1'b0;
  logic        prev_wr = 1'b1;
  logic [DW:0] lat = '0;

  function automatic void build_init();
    logic [DW+1:0] w;
    exp_init.delete();
    for (int a = 0; a < ROM_N; a++) begin
      w = rom[a];
      if (!w[DW+1]) break;
      exp_init.push_back(w[DW:0]);
    end
    exp_init.push_back({1'b0, 16'h2900});
  endfunction

  always @(negedge clk) begin
    sample_no++;
    if (!s_resetn) begin
      build_init();
      m_fifo.delete();
      m_count = 0; m_ready = 1'b0; m_done = 1'b0;
      hold_edges = 0; since = P; writes = 0; low_run = 0; had_write = 1'b0;
      chk("rst_wr", 32'(lcd_hw_wr), 32'(1));
      chk("rst_hw_rst", 32'(lcd_hw_rst), 32'(0));
      chk("rst_ready", 32'(cmd_ready), 32'(0));
      chk("rst_count", 32'(fifo_count), 32'(0));
      chk("rst_busy", 32'(busy), 32'(1));
      chk("rst_done", 32'(init_done), 32'(0));
    end else begin
      hold_edges++;
      if (prev_wr && !lcd_hw_wr) begin
        chk("fall_after_hold", 32'(hold_edges > RSTC), 32'(1));
        if (had_write) chk("wr_period_min", 32'(since + 1 >= P), 32'(1));
        if (writes < exp_init.size()) begin
          chk("init_word", 32'({lcd_hw_rs, lcd_hw_data}), 32'(exp_init[writes]));
        end else if (m_fifo.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=0x%0h required=none at %0t", {lcd_hw_rs, lcd_hw_data}, $time);
        end else begin
          chk("fifo_word", 32'({lcd_hw_rs, lcd_hw_data}), 32'(m_fifo.pop_front()));
          m_count--;
        end
        writes++; since = 0; had_write = 1'b1;
        lat = {lcd_hw_rs, lcd_hw_data};
        bus_log.push_back(lat);
        fall_t.push_back(sample_no);
      end else begin
        since++;
        if (had_write && since < P) chk("bus_stable", 32'({lcd_hw_rs, lcd_hw_data}), 32'(lat));
      end
      if (!prev_wr && lcd_hw_wr) begin
        chk("wr_low_width", 32'(low_run), 32'(WL));
        low_run = 0;
      end
      if (!lcd_hw_wr) low_run++;
      if (s_valid && m_ready) begin
        m_fifo.push_back({s_rs, s_data});
        m_count++;
      end
      m_ready = (m_count != DEPTH);
      if (writes == exp_init.size() && since >= P) m_done = 1'b1;
      chk("hw_rst", 32'(lcd_hw_rst), 32'(hold_edges >= RSTC));
      chk("fifo_count", 32'(fifo_count), 32'(m_count));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
      chk("init_done", 32'(init_done), 32'(m_done));
      chk("busy", 32'(busy), 32'(!(m_done && m_count == 0 && since >= P)));
      if (hold_edges <= RSTC) chk("hold_wr", 32'(lcd_hw_wr), 32'(1));
    end
    chk("const_strobes", 32'({lcd_hw_cs, lcd_hw_rd, lcd_hw_bl_ctr}), 32'(3'b011));
    prev_wr = lcd_hw_wr;
  end

  task automatic push_word(input logic rs, input logic [DW-1:0] d);
    int   n;
    logic r;
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d; n = 0;
    do begin
      r = cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 500);
    chk("push_accepted", 32'(r), 32'(1));
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!init_done && n < bound) begin @(posedge clk); #1; n++; end
    chk("init_done_reached", 32'(init_done), 32'(1));
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin @(posedge clk); #1; n++; end
    chk("idle_reached", 32'(busy), 32'(0));
  endtask

  task automatic chk_log(input string name, input int idx, input logic [DW:0] req);
    logic [DW:0] v;
    v = (idx < bus_log.size()) ? bus_log[idx] : 'x;
    chk(name, 32'(v), 32'(req));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    logic [DW:0] lit[$];

    for (int a = 0; a < ROM_N; a++) rom[a] = '0;
    rom[0] = {1'b1, 1'b0, 16'h1100};
    rom[1] = {1'b1, 1'b1, 16'h00AA};
    rom[2] = {1'b1, 1'b0, 16'h3A00};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_init_addr", 32'(init_addr), 32'(0));
    chk("reset_rs", 32'(lcd_hw_rs), 32'(0));
    chk("reset_data", 32'(lcd_hw_data), 32'(0));
    chk("reset_wr", 32'(lcd_hw_wr), 32'(1));
    chk("reset_ready", 32'(cmd_ready), 32'(0));

    // Hard reset length
    resetn = 1'b1;
    n = 0;
    while (!lcd_hw_rst && n < 100) begin @(posedge clk); #1; n++; end
    chk("hw_rst_low_cycles", 32'(n), 32'(8));

    // Eight offers during INIT into a 4-deep FIFO
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 16'h00A0 + 16'(i);
      @(posedge clk); #1;
      if (i == 2) chk("ready_before_4th", 32'(cmd_ready), 32'(1));
      if (i == 3) chk("ready_after_4th", 32'(cmd_ready), 32'(0));
    end
    cmd_valid = 1'b0;
    chk("count_after_offers", 32'(fifo_count), 32'(4));
    chk("model_count_after_offers", 32'(m_count), 32'(4));
    chk("still_init", 32'(init_done), 32'(0));
    wait_done(300);
    wait_idle(300);
    lit = '{17'h01100, 17'h100AA, 17'h03A00, 17'h02900,
            17'h100A0, 17'h100A1, 17'h100A2, 17'h100A3};
    chk("log_size_init", 32'(bus_log.size()), 32'(8));
    for (int k = 0; k < 8; k++) chk_log("log_init_seq", k, lit[k]);

    // Back-to-back burst in RUN
    base = bus_log.size();
    for (int i = 1; i <= 5; i++) push_word(1'b1, 16'(i));
    wait_idle(300);
    chk("log_size_burst", 32'(bus_log.size()), 32'(base + 5));
    for (int k = 0; k < 5; k++) chk_log("log_burst", base + k, {1'b1, 16'(k + 1)});
    for (int k = 1; k < 5; k++)
      if (base + k < fall_t.size())
        chk("burst_period", 32'(fall_t[base + k] - fall_t[base + k - 1]), 32'(5));

    // Reset during the second WR_LOW cycle
    base = bus_log.size();
    push_word(1'b1, 16'h0055);
    push_word(1'b1, 16'h0066);
    n = 0;
    while (lcd_hw_wr && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("abort_wr_low2", 32'(lcd_hw_wr), 32'(0));
    chk("abort_count_before", 32'(fifo_count), 32'(1));
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_wr_high", 32'(lcd_hw_wr), 32'(1));
    chk("abort_count", 32'(fifo_count), 32'(0));
    chk("abort_hw_rst", 32'(lcd_hw_rst), 32'(0));
    chk("abort_busy", 32'(busy), 32'(1));
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_done(300);
    wait_idle(300);
    lit = '{17'h10055, 17'h01100, 17'h100AA, 17'h03A00, 17'h02900};
    chk("log_size_abort", 32'(bus_log.size()), 32'(base + 5));
    for (int k = 0; k < 5; k++) chk_log("log_abort", base + k, lit[k]);

    // Full-depth ROM
    resetn = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < ROM_N; a++) rom[a] = {1'b1, a[0], 16'(a) ^ 16'h5A5A};
    @(posedge clk); #1;
    base = bus_log.size();
    resetn = 1'b1;
    wait_done(8000);
    chk("log_size_full", 32'(bus_log.size()), 32'(base + 1025));
    chk_log("full_first", base, 17'h05A5A);
    chk_log("full_second", base + 1, 17'h15A5B);
    chk_log("full_mid", base + 511, 17'h15BA5);
    chk_log("full_last", base + 1023, 17'h159A5);
    chk_log("full_dispon", base + 1024, 17'h02900);
    chk("full_addr_no_wrap", 32'(init_addr), 32'(1023));
    repeat (10) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
